// File: rtl/quick_spi_pkg.sv
// Shared types and constants for the quick SPI master.
// Build option: define QUICK_SPI_LSB_FIRST_EN to shift both directions LSB-first.
package quick_spi_pkg;

  localparam int unsigned DefaultNumSlaves = 2;
  localparam int unsigned DefaultOutWidth  = 16;
  localparam int unsigned DefaultInWidth   = 8;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

`ifdef QUICK_SPI_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StTransfer,
    StDone
  } state_e;

endpackage

// File: rtl/quick_spi_master_if.sv
// Controller-side and SPI-side signals of the quick SPI master.
// The master modport is the design view; peer is the view of whatever drives and observes it.
interface quick_spi_master_if
  import quick_spi_pkg::*;
#(
  parameter int unsigned NUMBER_OF_SLAVES    = DefaultNumSlaves,
  parameter int unsigned OUTGOING_DATA_WIDTH = DefaultOutWidth,
  parameter int unsigned INCOMING_DATA_WIDTH = DefaultInWidth
);
  logic                           enable;
  logic                           start_transaction;
  logic [NUMBER_OF_SLAVES-1:0]    slave;
  logic                           operation;
  logic                           end_of_transaction;
  logic [INCOMING_DATA_WIDTH-1:0] incoming_data;
  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data;
  logic                           mosi;
  logic                           miso;
  logic                           sclk;
  logic [NUMBER_OF_SLAVES-1:0]    ss_n;

  modport master (
    input  enable, start_transaction, slave, operation, outgoing_data, miso,
    output end_of_transaction, incoming_data, mosi, sclk, ss_n
  );

  modport peer (
    output enable, start_transaction, slave, operation, outgoing_data, miso,
    input  end_of_transaction, incoming_data, mosi, sclk, ss_n
  );
endinterface

// File: rtl/quick_spi_shifter.sv
// Parallel-load shift register with serial in/out; LsbFirst selects shift direction.
// Reset is synchronous, active-low.
module quick_spi_shifter #(
  parameter int unsigned Width    = 8,
  parameter bit          LsbFirst = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic [Width-1:0] data_o
);
  logic [Width-1:0] shreg_q;

  // Clear has priority over load, load over shift.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= LsbFirst ? {serial_i, shreg_q[Width-1:1]} : {shreg_q[Width-2:0], serial_i};
    end
  end

  // Head bit is the one leaving next; zeros fill in behind it.
  always_comb begin
    serial_o = LsbFirst ? shreg_q[0] : shreg_q[Width-1];
    data_o   = shreg_q;
  end
endmodule

// File: rtl/quick_spi_master.sv
// Mode-0 SPI master: write shifts a word out; read shifts it out then captures a reply.
// sclk runs at clk/2. Build option QUICK_SPI_LSB_FIRST_EN makes both directions LSB-first.
module quick_spi_master
  import quick_spi_pkg::*;
#(
  parameter int unsigned NUMBER_OF_SLAVES    = DefaultNumSlaves,
  parameter int unsigned OUTGOING_DATA_WIDTH = DefaultOutWidth,
  parameter int unsigned INCOMING_DATA_WIDTH = DefaultInWidth
) (
  input logic               clk,
  input logic               reset_n,
  quick_spi_master_if.master bus
);
  localparam int unsigned WrToggles = 2 * OUTGOING_DATA_WIDTH;
  localparam int unsigned RdToggles = 2 * (OUTGOING_DATA_WIDTH + INCOMING_DATA_WIDTH);
  localparam int unsigned CntW      = $clog2(RdToggles + 1);

  state_e                         state_q;
  logic                           sclk_q;
  logic [CntW-1:0]                cnt_q;
  logic                           op_q;
  logic                           eot_q;
  logic [NUMBER_OF_SLAVES-1:0]    ss_n_q;
  logic [INCOMING_DATA_WIDTH-1:0] rd_data_q;

  logic                           start, abort, last_toggle;
  logic                           tx_shift, rx_shift;
  logic [CntW-1:0]                total;
  logic                           tx_serial;
  logic [INCOMING_DATA_WIDTH-1:0] rx_data;
  logic                           unused_rx_serial;
  logic [OUTGOING_DATA_WIDTH-1:0] unused_tx_data;

  // Shift strobes: tx advances on falling sclk toggles, rx samples on rising ones after the
  // out-bits of a read.
  always_comb begin
    start       = (state_q == StIdle) && bus.enable && bus.start_transaction;
    abort       = (state_q == StTransfer) && !bus.enable;
    total       = (op_q == OP_READ) ? CntW'(RdToggles) : CntW'(WrToggles);
    last_toggle = (cnt_q + CntW'(1)) == total;
    tx_shift    = (state_q == StTransfer) && bus.enable && sclk_q;
    rx_shift    = (state_q == StTransfer) && bus.enable && !sclk_q && (op_q == OP_READ) &&
                  (cnt_q >= CntW'(WrToggles));
  end

  quick_spi_shifter #(
    .Width    (OUTGOING_DATA_WIDTH),
    .LsbFirst (LsbFirst)
  ) u_tx (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clear_i  (abort),
    .load_i   (start),
    .data_i   (bus.outgoing_data),
    .shift_i  (tx_shift),
    .serial_i (1'b0),
    .serial_o (tx_serial),
    .data_o   (unused_tx_data)
  );

  quick_spi_shifter #(
    .Width    (INCOMING_DATA_WIDTH),
    .LsbFirst (LsbFirst)
  ) u_rx (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clear_i  (start),
    .load_i   (1'b0),
    .data_i   ('0),
    .shift_i  (rx_shift),
    .serial_i (bus.miso),
    .serial_o (unused_rx_serial),
    .data_o   (rx_data)
  );

  // Transaction FSM with registered sclk, slave selects, completion pulse and read result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sclk_q    <= 1'b0;
      cnt_q     <= '0;
      op_q      <= OP_WRITE;
      eot_q     <= 1'b0;
      ss_n_q    <= '1;
      rd_data_q <= '0;
    end else begin
      eot_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ss_n_q <= '1;
          if (start) begin
            op_q    <= bus.operation;
            ss_n_q  <= ~bus.slave;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StTransfer;
          end
        end
        StTransfer: begin
          if (!bus.enable) begin
            state_q <= StIdle;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            ss_n_q  <= '1;
          end else begin
            sclk_q <= ~sclk_q;
            cnt_q  <= cnt_q + CntW'(1);
            if (last_toggle) state_q <= StDone;
          end
        end
        StDone: begin
          eot_q  <= 1'b1;
          ss_n_q <= '1;
          if (op_q == OP_READ) rd_data_q <= rx_data;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sclk               = sclk_q;
  assign bus.mosi               = tx_serial;
  assign bus.ss_n               = ss_n_q;
  assign bus.end_of_transaction = eot_q;
  assign bus.incoming_data      = rd_data_q;
endmodule

// File: tb/tb_quick_spi_master.sv
// Self-checking bench for quick_spi_master: directed and random transactions checked
// against a bit-level reference model of the serial protocol.
module tb_quick_spi_master;
  localparam int NS = 2;
  localparam int OW = 16;
  localparam int IW = 8;
`ifdef QUICK_SPI_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  quick_spi_master_if #(
    .NUMBER_OF_SLAVES    (NS),
    .OUTGOING_DATA_WIDTH (OW),
    .INCOMING_DATA_WIDTH (IW)
  ) bus ();

  quick_spi_master #(
    .NUMBER_OF_SLAVES    (NS),
    .OUTGOING_DATA_WIDTH (OW),
    .INCOMING_DATA_WIDTH (IW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [IW-1:0] exp_rd;

  // i-th bit on the wire for an outgoing word / incoming word.
  function automatic logic tx_bit(input logic [OW-1:0] d, input int i);
    return LsbFirst ? d[i] : d[OW-1-i];
  endfunction

  function automatic logic rx_bit(input logic [IW-1:0] v, input int i);
    return LsbFirst ? v[i] : v[IW-1-i];
  endfunction

  // Follows one transaction whose start edge is the next posedge; returns at the end pulse.
  task automatic observe_txn(input string name, input logic op, input logic [OW-1:0] d,
                             input logic [NS-1:0] sl, input logic [IW-1:0] rxv, input bit hold);
    int n_bits, rises, toggles, ss_bad, tail_bad, lat;
    logic prev_sclk;
    logic [OW-1:0] got_tx, exp_tx;
    bit seen;
    n_bits = OW + (op ? IW : 0);
    for (int i = 0; i < OW; i++) exp_tx[i] = tx_bit(d, i);
    got_tx = '0; rises = 0; toggles = 0; ss_bad = 0; tail_bad = 0; lat = -1; seen = 0;
    prev_sclk = 1'b0;
    if (op) exp_rd = rxv;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && !hold) bus.start_transaction = 1'b0;
      if (cyc == 3) begin
        bus.operation     = 1'($urandom);
        bus.outgoing_data = OW'($urandom);
        bus.slave         = NS'($urandom);
      end
      if (bus.end_of_transaction) begin
        seen = 1;
        lat  = cyc;
        checks++;
        if (bus.incoming_data !== exp_rd)
          $display("FAIL %s.incoming_data: got %h expected %h", name, bus.incoming_data, exp_rd);
        else passed++;
        checks++;
        if (bus.ss_n !== {NS{1'b1}} || bus.sclk !== 1'b0)
          $display("FAIL %s.end_lines: got ss_n=%b sclk=%b expected ss_n=%b sclk=0", name,
                   bus.ss_n, bus.sclk, {NS{1'b1}});
        else passed++;
      end else begin
        if (bus.ss_n !== ~sl) ss_bad++;
        if (bus.sclk !== prev_sclk) toggles++;
        if (bus.sclk && !prev_sclk) begin
          if (rises < OW) got_tx[rises] = bus.mosi;
          rises++;
        end
        if (!bus.sclk && rises >= OW && bus.mosi !== 1'b0) tail_bad++;
        if (!bus.sclk) begin
          if (rises >= OW && rises < OW + IW) bus.miso = rx_bit(rxv, rises - OW);
          else bus.miso = 1'($urandom);
        end
        prev_sclk = bus.sclk;
      end
    end
    checks++;
    if (lat != 2 * n_bits + 1)
      $display("FAIL %s.latency: got %0d expected %0d", name, lat, 2 * n_bits + 1);
    else passed++;
    checks++;
    if (toggles != 2 * n_bits)
      $display("FAIL %s.toggles: got %0d expected %0d", name, toggles, 2 * n_bits);
    else passed++;
    checks++;
    if (got_tx !== exp_tx)
      $display("FAIL %s.mosi_bits: got %b expected %b (bit0 = first on wire)", name, got_tx,
               exp_tx);
    else passed++;
    checks++;
    if (ss_bad != 0) $display("FAIL %s.ss_n_hold: got %0d bad cycles expected 0", name, ss_bad);
    else passed++;
    checks++;
    if (tail_bad != 0) $display("FAIL %s.mosi_tail: got %0d nonzero expected 0", name, tail_bad);
    else passed++;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.start_transaction = 1'b0; bus.slave = '0; bus.operation = 1'b0;
    bus.outgoing_data = '0; bus.miso = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.sclk !== 1'b0 || bus.mosi !== 1'b0 || bus.ss_n !== {NS{1'b1}} ||
        bus.end_of_transaction !== 1'b0 || bus.incoming_data !== '0)
      $display("FAIL reset: got sclk=%b mosi=%b ss_n=%b eot=%b in=%h expected 0 0 11 0 00",
               bus.sclk, bus.mosi, bus.ss_n, bus.end_of_transaction, bus.incoming_data);
    else passed++;
    exp_rd = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single(input string name, input logic op, input logic [OW-1:0] d,
                             input logic [NS-1:0] sl, input logic [IW-1:0] rxv);
    @(negedge clk);
    bus.enable = 1'b1; bus.start_transaction = 1'b1; bus.operation = op;
    bus.outgoing_data = d; bus.slave = sl;
    observe_txn(name, op, d, sl, rxv, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.end_of_transaction !== 1'b0 || bus.ss_n !== {NS{1'b1}} || bus.sclk !== 1'b0)
      $display("FAIL %s.idle_after: got eot=%b ss_n=%b sclk=%b expected 0 11 0", name,
               bus.end_of_transaction, bus.ss_n, bus.sclk);
    else passed++;
  endtask

  task automatic test_write();
    test_single("write_5a5a", 1'b0, 16'h5A5A, 2'b01, 8'h00);
  endtask

  task automatic test_read();
    test_single("read_ca", 1'b1, 16'h5A5A, 2'b01, 8'hCA);
  endtask

  // Wait until n sclk toggles are visible; returns the count actually seen.
  task automatic wait_toggles(input int n, output int seen_toggles);
    logic prev;
    prev = 1'b0;
    seen_toggles = 0;
    for (int cyc = 0; cyc < 200 && seen_toggles < n; cyc++) begin
      @(negedge clk);
      bus.start_transaction = 1'b0;
      if (bus.sclk !== prev) seen_toggles++;
      prev = bus.sclk;
    end
  endtask

  task automatic test_abort();
    int tg, eot_cnt, ss_cnt;
    @(negedge clk);
    bus.enable = 1'b1; bus.start_transaction = 1'b1; bus.operation = 1'b1;
    bus.outgoing_data = OW'($urandom); bus.slave = 2'b01;
    wait_toggles(10, tg);
    checks++;
    if (tg != 10) $display("FAIL abort.reach: got %0d toggles expected 10", tg);
    else passed++;
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sclk !== 1'b0 || bus.ss_n !== {NS{1'b1}} || bus.end_of_transaction !== 1'b0)
      $display("FAIL abort.lines: got sclk=%b ss_n=%b eot=%b expected 0 11 0", bus.sclk,
               bus.ss_n, bus.end_of_transaction);
    else passed++;
    // Disabled block must ignore a held start and never complete the aborted transfer.
    bus.start_transaction = 1'b1;
    eot_cnt = 0; ss_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.end_of_transaction) eot_cnt++;
      if (bus.ss_n !== {NS{1'b1}} || bus.sclk !== 1'b0) ss_cnt++;
    end
    checks++;
    if (eot_cnt != 0 || ss_cnt != 0)
      $display("FAIL abort.quiet: got eot=%0d active=%0d expected 0 0", eot_cnt, ss_cnt);
    else passed++;
    checks++;
    if (bus.incoming_data !== exp_rd)
      $display("FAIL abort.incoming_data: got %h expected %h", bus.incoming_data, exp_rd);
    else passed++;
    bus.start_transaction = 1'b0;
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    int tg;
    @(negedge clk);
    bus.enable = 1'b1; bus.start_transaction = 1'b1; bus.operation = 1'b1;
    bus.outgoing_data = OW'($urandom); bus.slave = 2'b10;
    wait_toggles(40, tg);
    checks++;
    if (tg != 40) $display("FAIL rst_mid.reach: got %0d toggles expected 40", tg);
    else passed++;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sclk !== 1'b0 || bus.mosi !== 1'b0 || bus.ss_n !== {NS{1'b1}} ||
        bus.end_of_transaction !== 1'b0 || bus.incoming_data !== '0)
      $display("FAIL rst_mid.values: got sclk=%b mosi=%b ss_n=%b eot=%b in=%h expected 0 0 11 0 00",
               bus.sclk, bus.mosi, bus.ss_n, bus.end_of_transaction, bus.incoming_data);
    else passed++;
    exp_rd = '0;
    reset_n = 1'b1;
    test_single("rst_mid.after", 1'b1, OW'($urandom), 2'b10, IW'($urandom));
  endtask

  task automatic test_back_to_back();
    logic op;
    logic [OW-1:0] d;
    logic [NS-1:0] sl;
    logic [IW-1:0] rxv;
    @(negedge clk);
    op = 1'b0;
    bus.enable = 1'b1; bus.start_transaction = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = OW'($urandom); sl = NS'($urandom_range(1, (1 << NS) - 1)); rxv = IW'($urandom);
      bus.operation = op; bus.outgoing_data = d; bus.slave = sl;
      observe_txn($sformatf("b2b%0d", k), op, d, sl, rxv, k < 3);
      op = ~op;
    end
    @(negedge clk);
    checks++;
    if (bus.end_of_transaction !== 1'b0 || bus.ss_n !== {NS{1'b1}})
      $display("FAIL b2b.idle_after: got eot=%b ss_n=%b expected 0 11",
               bus.end_of_transaction, bus.ss_n);
    else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      test_single($sformatf("rand%0d", k), 1'($urandom), OW'($urandom), NS'($urandom),
                  IW'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
